// File: rtl/bank_cmd_arbiter_pkg.sv
// Shared command types for the rank command arbiter: scheduler command codes,
// the issue FIFO word, command classes and the output register states.
`ifndef BA_BITS
`define BA_BITS 3
`endif
`ifndef ROW_BITS
`define ROW_BITS 14
`endif
`ifndef COL_BITS
`define COL_BITS 10
`endif

package bank_cmd_arbiter_pkg;

   localparam int unsigned BA_W   = `BA_BITS;
   localparam int unsigned ADDR_W = `COL_BITS + `ROW_BITS;

   typedef enum logic [3:0] {
      ATCMD_NOP       = 4'd0,
      ATCMD_ACTIVE    = 4'd1,
      ATCMD_READ      = 4'd2,
      ATCMD_WRITE     = 4'd3,
      ATCMD_RDA       = 4'd4,
      ATCMD_WRA       = 4'd5,
      ATCMD_PRECHARGE = 4'd6,
      ATCMD_REFRESH   = 4'd7,
      ATCMD_POWER_D   = 4'd8,
      ATCMD_POWER_U   = 4'd9
   } sch_cmd_t;

   typedef struct packed {
      sch_cmd_t            command;
      logic [ADDR_W-1:0]   addr;
      logic [BA_W-1:0]     bank;
   } issue_fifo_cmd_in_t;

   typedef enum logic [1:0] {
      CLS_ACT,
      CLS_COL_RD,
      CLS_COL_WR,
      CLS_OTHER
   } cmd_class_t;

   typedef enum logic {
      OUT_EMPTY,
      OUT_FULL
   } out_state_t;

   function automatic cmd_class_t sch_cmd_to_class(input sch_cmd_t cmd);
      cmd_class_t cls;
      case (cmd)
         ATCMD_ACTIVE:           cls = CLS_ACT;
         ATCMD_READ, ATCMD_RDA:  cls = CLS_COL_RD;
         ATCMD_WRITE, ATCMD_WRA: cls = CLS_COL_WR;
         default:                cls = CLS_OTHER;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/bank_cmd_arbiter_rr_pick.sv
// Round-robin first-one finder: returns the first set bit of eligible at or
// above rr_ptr, wrapping past N-1 back to 0, as a one-hot vector.
module rr_pick #(
   parameter int unsigned N     = 8,
   parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     eligible,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic [N-1:0]     pick
);

   logic             found;
   logic [PTR_W-1:0] idx;

   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = PTR_W'((k + 32'(rr_ptr)) % N);
         if (!found && eligible[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bank_cmd_arbiter.sv
// Rank-level command arbiter: REFRESH-first, then round-robin among banks that
// meet tRRD/tCCD/tWTR; winner registered for the issue FIFO. Optional perf
// counters under BANK_CMD_ARB_PERF_EN.
module bank_cmd_arbiter
   import bank_cmd_arbiter_pkg::*;
#(
   parameter int unsigned NUM_BANKS = 8,
   parameter int unsigned T_RRD     = 4,
   parameter int unsigned T_CCD     = 4,
   parameter int unsigned T_WTR     = 6,
   parameter int unsigned CNT_W     = 4
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_BANKS-1:0]                 req_valid,
   input  logic [NUM_BANKS*4-1:0]               req_cmd,
   input  logic [NUM_BANKS*ADDR_W-1:0]          req_addr,
   output logic [NUM_BANKS-1:0]                 req_grant,
   output logic                                 out_valid,
   output logic [$bits(issue_fifo_cmd_in_t)-1:0] out_cmd,
   input  logic                                 out_ready
`ifdef BANK_CMD_ARB_PERF_EN
   ,
   output logic [31:0]                          perf_issue_cnt,
   output logic [31:0]                          perf_block_cnt
`endif
);

   localparam int unsigned PTR_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

   out_state_t           state, state_nxt;
   logic [CNT_W-1:0]     cnt_rrd, cnt_ccd, cnt_wtr;
   logic [PTR_W-1:0]     rr_ptr;
   sch_cmd_t             bank_cmd [NUM_BANKS];
   logic [NUM_BANKS-1:0] elig, ref_elig, ref_pick, rr_onehot;
   logic                 grant_en, gnt_any;
   logic [PTR_W-1:0]     gnt_idx;
   cmd_class_t           gnt_cls;
   issue_fifo_cmd_in_t   gnt_word;

   assign out_valid = (state == OUT_FULL);
   assign grant_en  = !out_valid || out_ready;

   always_comb begin
      elig     = '0;
      ref_elig = '0;
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
         bank_cmd[i] = sch_cmd_t'(req_cmd[4*i +: 4]);
         if (req_valid[i] && (bank_cmd[i] != ATCMD_NOP)) begin
            unique case (sch_cmd_to_class(bank_cmd[i]))
               CLS_ACT:    elig[i] = (cnt_rrd == '0);
               CLS_COL_RD: elig[i] = (cnt_ccd == '0) && (cnt_wtr == '0);
               CLS_COL_WR: elig[i] = (cnt_ccd == '0);
               default:    elig[i] = 1'b1;
            endcase
         end
         ref_elig[i] = elig[i] && (bank_cmd[i] == ATCMD_REFRESH);
      end
   end

   // Lowest-index refresh: isolate the least significant set bit.
   assign ref_pick = ref_elig & (~ref_elig + NUM_BANKS'(1));

   rr_pick #(
      .N     (NUM_BANKS),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .eligible (elig),
      .rr_ptr   (rr_ptr),
      .pick     (rr_onehot)
   );

   always_comb begin
      req_grant = '0;
      if (grant_en) begin
         req_grant = (|ref_elig) ? ref_pick : rr_onehot;
      end
   end

   assign gnt_any = |req_grant;

   always_comb begin
      gnt_idx = '0;
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
         if (req_grant[i]) begin
            gnt_idx = PTR_W'(i);
         end
      end
   end

   always_comb begin
      gnt_word.command = bank_cmd[gnt_idx];
      gnt_word.addr    = req_addr[ADDR_W*32'(gnt_idx) +: ADDR_W];
      gnt_word.bank    = BA_W'(gnt_idx);
      gnt_cls          = sch_cmd_to_class(bank_cmd[gnt_idx]);
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         OUT_EMPTY: if (gnt_any) state_nxt = OUT_FULL;
         OUT_FULL:  if (out_ready && !gnt_any) state_nxt = OUT_EMPTY;
         default:   state_nxt = OUT_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= OUT_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_cmd <= '0;
         rr_ptr  <= '0;
      end else if (gnt_any) begin
         out_cmd <= gnt_word;
         rr_ptr  <= PTR_W'((32'(gnt_idx) + 1) % NUM_BANKS);
      end
   end

   // Counters run during output stalls: spacing is measured grant-to-grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_rrd <= '0;
         cnt_ccd <= '0;
         cnt_wtr <= '0;
      end else begin
         if (gnt_any && gnt_cls == CLS_ACT) cnt_rrd <= CNT_W'(T_RRD - 1);
         else if (cnt_rrd != '0)              cnt_rrd <= cnt_rrd - 1'b1;

         if (gnt_any && (gnt_cls == CLS_COL_RD || gnt_cls == CLS_COL_WR))
            cnt_ccd <= CNT_W'(T_CCD - 1);
         else if (cnt_ccd != '0)
            cnt_ccd <= cnt_ccd - 1'b1;

         if (gnt_any && gnt_cls == CLS_COL_WR) cnt_wtr <= CNT_W'(T_WTR - 1);
         else if (cnt_wtr != '0)                 cnt_wtr <= cnt_wtr - 1'b1;
      end
   end

`ifdef BANK_CMD_ARB_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_issue_cnt <= '0;
         perf_block_cnt <= '0;
      end else begin
         if (gnt_any && perf_issue_cnt != '1) perf_issue_cnt <= perf_issue_cnt + 1'b1;
         if ((|req_valid) && grant_en && !gnt_any && perf_block_cnt != '1)
            perf_block_cnt <= perf_block_cnt + 1'b1;
      end
   end
`endif

endmodule
